// File: rtl/commit_trace_if.sv
// Commit-side and trace-side signal bundle for commit_trace_buffer.
// The slave modport is the buffer; the master modport is the core/consumer side.
interface commit_trace_if #(
    parameter int PTR_W = 3
);
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [31:0]      commit_instr;
    logic             wb_wreg;
    logic [4:0]       wb_wd;
    logic [31:0]      wb_wdata;
    logic             trace_ready;
    logic             clr_overflow;

    logic             trace_valid;
    logic [31:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic             trace_wen;
    logic [4:0]       trace_wnum;
    logic [31:0]      trace_wdata;
    logic [31:0]      trace_seq;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [15:0]      drop_cnt;

    modport master (
        output commit_valid, commit_pc, commit_instr, wb_wreg, wb_wd, wb_wdata,
               trace_ready, clr_overflow,
        input  trace_valid, trace_pc, trace_instr, trace_wen, trace_wnum,
               trace_wdata, trace_seq, count, overflow, drop_cnt
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, wb_wreg, wb_wd, wb_wdata,
               trace_ready, clr_overflow,
        output trace_valid, trace_pc, trace_instr, trace_wen, trace_wnum,
               trace_wdata, trace_seq, count, overflow, drop_cnt
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retired-instruction trace FIFO: stamps each accepted commit with a sequence
// number and buffers it for a downstream difftest/trace consumer; counts drops.
module commit_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    commit_trace_if.slave tif
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] seq;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      seq_next_q, seq_next_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic   full, pop, push, drop;
    entry_t new_entry;
    entry_t head;

    always_comb begin
        full = (count_q == FULL_CNT);
        pop  = (count_q != '0) && tif.trace_ready;
        push = tif.commit_valid && (!full || pop);
        drop = tif.commit_valid && full && !pop;

        // Non-writing and x0-writing commits are normalised so the consumer
        // can compare wnum/wdata without consulting wen first.
        new_entry.pc    = tif.commit_pc;
        new_entry.instr = tif.commit_instr;
        new_entry.wen   = tif.wb_wreg && (tif.wb_wd != 5'd0);
        new_entry.wnum  = new_entry.wen ? tif.wb_wd : 5'd0;
        new_entry.wdata = new_entry.wen ? tif.wb_wdata : 32'd0;
        new_entry.seq   = seq_next_q;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_next_d = seq_next_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            seq_next_d      = seq_next_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear restarts the tally at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (tif.clr_overflow) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (tif.clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_next_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_next_q <= seq_next_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign tif.trace_valid = (count_q != '0);
    assign tif.trace_pc    = head.pc;
    assign tif.trace_instr = head.instr;
    assign tif.trace_wen   = head.wen;
    assign tif.trace_wnum  = head.wnum;
    assign tif.trace_wdata = head.wdata;
    assign tif.trace_seq   = head.seq;
    assign tif.count       = count_q;
    assign tif.overflow    = overflow_q;
    assign tif.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] seq;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_trace_if #(.PTR_W(PTR_W)) bus ();

    commit_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .tif (bus.slave)
    );

    ent_t        mq[$];
    ent_t        exp_q[$];
    int unsigned seq_m;
    bit          ovf_m;
    int          drop_m;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle, advance the model, then check state just after the edge.
    task automatic step(input bit cv, input logic [31:0] pc, input logic [31:0] instr,
                        input bit wreg, input logic [4:0] wd, input logic [31:0] wdata,
                        input bit rdy, input bit clr, input bit r);
        bit   pop, full, push, drop;
        ent_t e;
        bus.commit_valid = cv;
        bus.commit_pc    = pc;
        bus.commit_instr = instr;
        bus.wb_wreg      = wreg;
        bus.wb_wd        = wd;
        bus.wb_wdata     = wdata;
        bus.trace_ready  = rdy;
        bus.clr_overflow = clr;
        rst              = r;
        if (r) begin
            mq.delete();
            exp_q.delete();
            seq_m  = 0;
            ovf_m  = 0;
            drop_m = 0;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            full = (mq.size() == DEPTH);
            push = cv && (!full || pop);
            drop = cv && full && !pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc    = pc;
                e.instr = instr;
                e.wen   = wreg && (wd != 0);
                e.wnum  = e.wen ? wd : 5'd0;
                e.wdata = e.wen ? wdata : 32'd0;
                e.seq   = seq_m;
                mq.push_back(e);
                exp_q.push_back(e);
                seq_m++;
            end
            if (drop) begin
                ovf_m  = 1;
                drop_m = clr ? 1 : ((drop_m < 65535) ? drop_m + 1 : drop_m);
            end else if (clr) begin
                ovf_m  = 0;
                drop_m = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("count", bus.count, mq.size());
        chk("trace_valid", bus.trace_valid, mq.size() != 0);
        chk("overflow", bus.overflow, ovf_m);
        chk("drop_cnt", bus.drop_cnt, drop_m);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, rdy, 0, 0);
    endtask

    task automatic commit(input logic [31:0] pc, input bit rdy);
        step(1, pc, pc ^ 32'h0280_0000, 1, pc[6:2], pc + 32'd7, rdy, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) idle(1);
        chk("drain_empty", bus.trace_valid, 0);
    endtask

    // Monitor: every handshake on the trace side consumes one expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (rst === 1'b0 && bus.trace_valid === 1'b1 && bus.trace_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow actual=pop expected=none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.trace_pc, e.pc);
                chk("sb_instr", bus.trace_instr, e.instr);
                chk("sb_wen", bus.trace_wen, e.wen);
                chk("sb_wnum", bus.trace_wnum, e.wnum);
                chk("sb_wdata", bus.trace_wdata, e.wdata);
                chk("sb_seq", bus.trace_seq, e.seq);
            end
        end
    end

    initial begin
        seq_m = 0; ovf_m = 0; drop_m = 0;
        step(1, 32'h1111, 0, 1, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_pc", bus.trace_pc, 0);
        chk("rst_instr", bus.trace_instr, 0);
        chk("rst_wdata", bus.trace_wdata, 0);
        chk("rst_seq", bus.trace_seq, 0);

        // Single commit, visible one cycle later, consumed the next.
        step(1, 32'h1C00_0000, 32'h0280_0421, 1, 5'd1, 32'd5, 1, 0, 0);
        chk("single_wen", bus.trace_wen, 1);
        chk("single_wnum", bus.trace_wnum, 1);
        chk("single_wdata", bus.trace_wdata, 5);
        chk("single_seq", bus.trace_seq, 0);
        idle(1);
        chk("single_gone", bus.trace_valid, 0);

        // Write to x0 is not a real write.
        step(1, 32'h1C00_0004, 32'h0280_0000, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("x0_wen", bus.trace_wen, 0);
        chk("x0_wdata", bus.trace_wdata, 0);
        drain();

        // Overfill with consumer stalled; head must not move while stalled.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) commit(32'h2000 + 4 * i, 0);
        chk("ovf_count", bus.count, 8);
        chk("ovf_drops", bus.drop_cnt, 2);
        chk("stall_pc", bus.trace_pc, 32'h2000);

        // Full with simultaneous pop: accepted, no drop.
        commit(32'h3000, 1);
        chk("fullpop_count", bus.count, 8);
        chk("fullpop_drops", bus.drop_cnt, 2);
        drain();

        // Clear racing a drop, then a lone clear.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) commit(32'h4000 + 4 * i, 0);
        chk("pre_clr_drops", bus.drop_cnt, 3);
        step(1, 32'h5000, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_race_ovf", bus.overflow, 1);
        chk("clr_race_drops", bus.drop_cnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_ovf", bus.overflow, 0);
        chk("clr_drops", bus.drop_cnt, 0);
        drain();

        // Reset mid-operation with a commit present.
        for (int i = 0; i < 4; i++) commit(32'h6000 + 4 * i, 0);
        step(1, 32'h7000, 0, 1, 3, 3, 1, 0, 1);
        chk("midrst_count", bus.count, 0);
        chk("midrst_pc", bus.trace_pc, 0);
        commit(32'h7004, 0);
        chk("midrst_seq", bus.trace_seq, 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc, rd;
            logic [4:0]  wd;
            rpc = $urandom;
            rd  = $urandom;
            wd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 3) != 0, rpc, $urandom, $urandom_range(0, 1) == 1, wd, rd,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 149) == 0);
        end
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 Parameter PTR_W, default 3, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high (sampled only on posedge clk).
REQ-005 commit_valid  input  1  one instruction retired this cycle (writeback-stage commit strobe).
REQ-006 commit_pc  input  32  PC of retired instruction.
REQ-007 commit_instr  input  32  encoding of retired instruction.
REQ-008 wb_wreg  input  1  retired instruction writes GPR.
REQ-009 wb_wd  input  5  destination GPR index.
REQ-010 wb_wdata  input  32  value written.
REQ-011 trace_ready  input  1  downstream trace/difftest consumer accepts head entry.
REQ-012 clr_overflow  input  1  clears overflow and drop_cnt.
REQ-013 trace_valid  output  1  head entry present.
REQ-014 trace_pc, trace_instr  output  32 each  head entry PC/encoding.
REQ-015 trace_wen  output  1  head entry performed a real GPR write.
REQ-016 trace_wnum  output  5  head entry destination index.
REQ-017 trace_wdata  output  32  head entry write data.
REQ-018 trace_seq  output  32  commit sequence number of head entry.
REQ-019 count  output  PTR_W+1  current occupancy, 0..DEPTH.
REQ-020 overflow  output  1  sticky: at least one commit dropped.
REQ-021 drop_cnt  output  16  dropped commits, saturating.

Function
REQ-022 Push = commit_valid && (!full || pop); pop = trace_valid && trace_ready; full = (count == DEPTH).
REQ-023 Accepted push writes entry at write pointer; pointers wrap modulo DEPTH via PTR_W-bit arithmetic.
REQ-024 Entry capture: trace_wen = wb_wreg && (wb_wd != 0); when trace_wen is 0, stored wnum and wdata are 0.
REQ-025 Push-to-visible latency is 1 cycle: entry pushed at edge N is presented with trace_valid=1 after edge N; no combinational input-to-output bypass.
REQ-026 trace_valid = (count != 0); trace_* outputs reflect head entry; with trace_valid=0 they hold last head contents (value is don't-care).
REQ-027 Output data is stable while trace_valid=1 and trace_ready=0.
REQ-028 Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-029 Full with simultaneous pop: push accepted, count stays DEPTH, no drop.
REQ-030 Empty: pop impossible (trace_valid=0); trace_ready ignored.
REQ-031 Sequence counter seq_next (32 bit) stamped into each accepted entry, then incremented; wraps 0xFFFFFFFF -> 0; dropped commits do not consume a number.
REQ-032 Drop = commit_valid && full && !pop: entry discarded, overflow set, drop_cnt +1 saturating at 0xFFFF.
REQ-033 clr_overflow: overflow<=0, drop_cnt<=0; a drop in the same cycle wins, giving overflow=1, drop_cnt=1.
REQ-034 FIFO contents never altered except by push; pop only advances read pointer.

Reset
REQ-035 rst=1 at a clock edge: pointers, count, seq_next=0; overflow=0; drop_cnt=0; trace_valid=0; all trace_* data outputs=0.
REQ-036 Reset has priority over push, pop and clr_overflow in the same cycle; a commit presented during reset is discarded and not counted as a drop.
REQ-037 Reset mid-operation discards all buffered entries; first commit after reset gets trace_seq=0.

Verification
REQ-038 Single commit pc=0x1C000000, instr=0x02800421, wb_wreg=1, wb_wd=1, wb_wdata=5, trace_ready=1 -> next cycle trace_valid=1, trace_wen=1, trace_wnum=1, trace_wdata=5, trace_seq=0; following cycle trace_valid=0.
REQ-039 Commit with wb_wreg=1, wb_wd=0, wb_wdata=0xDEADBEEF -> trace_wen=0, trace_wnum=0, trace_wdata=0.
REQ-040 trace_ready=0, 10 consecutive commits, DEPTH=8 -> count=8, overflow=1, drop_cnt=2; then drain -> 8 entries seq 0..7 in order, pcs match first 8.
REQ-041 Full FIFO, commit_valid=1 and trace_ready=1 same cycle -> count stays 8, no drop, new entry seq=8 emerges last.
REQ-042 overflow=1, drop_cnt=3, clr_overflow=1 with simultaneous drop -> overflow=1, drop_cnt=1; clr_overflow alone next -> 0, 0.
REQ-043 Four entries buffered, rst=1 for one cycle with commit_valid=1 -> count=0, trace_valid=0, drop_cnt=0; next commit gives trace_seq=0.
